// File: rtl/approx_mul_pkg.sv
// Shared constants and helpers for the quadrant-split approximate multiplier.
// Mode bit positions and the truncation mask used by each sub-product.
package approx_mul_pkg;

  localparam int MODE_LL = 0;
  localparam int MODE_LH = 1;
  localparam int MODE_HL = 2;
  localparam int MODE_HH = 3;

  // Widest sub-product the mask helper can describe (2H <= MAX_PW).
  localparam int MAX_PW = 64;

  // Ones on bits [2h-1:trunc], zeros on the truncated low bits and above 2h.
  function automatic logic [MAX_PW-1:0] trunc_mask(input int h, input int trunc);
    logic [MAX_PW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PW; i++) begin
      m[i] = (i < 2 * h) && (i >= trunc);
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_submul.sv
// Combinational H x H unsigned multiplier; when approx is set the low TRUNC
// bits of the product are forced to zero.
module approx_submul
  import approx_mul_pkg::*;
#(
  parameter int H     = 4,
  parameter int TRUNC = 2
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  input  logic           approx,
  output logic [2*H-1:0] p
);

  localparam logic [MAX_PW-1:0] MASK_ALL = trunc_mask(H, TRUNC);
  localparam logic [2*H-1:0]    MASK     = MASK_ALL[2*H-1:0];

  logic [2*H-1:0] full;

  assign full = (2*H)'(x) * (2*H)'(y);
  assign p    = approx ? (full & MASK) : full;

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage pipelined approximate multiplier: S1 registers operands, S2 forms
// four per-quadrant sub-products, S3 recombines them into prod.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int W     = 8,
  parameter int TRUNC = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [3:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   prod,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int H  = W / 2;
  localparam int PW = 2 * W;

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and data/valid hold while valid & !ready.
  // The whole pipe moves as one: every stage advances unless the output is stuck.
  logic adv;

  logic [W-1:0]     a1_q, a1_d, b1_q, b1_d;
  logic [3:0]       mode1_q, mode1_d;
  logic             v1_q, v1_d;
  logic [2*H-1:0]   ll2_q, ll2_d, lh2_q, lh2_d, hl2_q, hl2_d, hh2_q, hh2_d;
  logic             v2_q, v2_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             v3_q, v3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*H-1:0]   ll_w, lh_w, hl_w, hh_w;

  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign prod      = prod_q;
  assign done_cnt  = cnt_q;

  approx_submul #(.H(H), .TRUNC(TRUNC)) u_ll (
    .x(a1_q[H-1:0]), .y(b1_q[H-1:0]), .approx(mode1_q[MODE_LL]), .p(ll_w));
  approx_submul #(.H(H), .TRUNC(TRUNC)) u_lh (
    .x(a1_q[H-1:0]), .y(b1_q[W-1:H]), .approx(mode1_q[MODE_LH]), .p(lh_w));
  approx_submul #(.H(H), .TRUNC(TRUNC)) u_hl (
    .x(a1_q[W-1:H]), .y(b1_q[H-1:0]), .approx(mode1_q[MODE_HL]), .p(hl_w));
  approx_submul #(.H(H), .TRUNC(TRUNC)) u_hh (
    .x(a1_q[W-1:H]), .y(b1_q[W-1:H]), .approx(mode1_q[MODE_HH]), .p(hh_w));

  always_comb begin
    a1_d    = a1_q;
    b1_d    = b1_q;
    mode1_d = mode1_q;
    v1_d    = v1_q;
    ll2_d   = ll2_q;
    lh2_d   = lh2_q;
    hl2_d   = hl2_q;
    hh2_d   = hh2_q;
    v2_d    = v2_q;
    prod_d  = prod_q;
    v3_d    = v3_q;
    cnt_d   = cnt_q;
    if (adv) begin
      a1_d    = a;
      b1_d    = b;
      mode1_d = mode;
      v1_d    = in_valid;
      ll2_d   = ll_w;
      lh2_d   = lh_w;
      hl2_d   = hl_w;
      hh2_d   = hh_w;
      v2_d    = v1_q;
      // Exact maximum fits in PW bits, and truncation only lowers each term.
      prod_d  = PW'(ll2_q) + (PW'(lh2_q) << H) + (PW'(hl2_q) << H) + (PW'(hh2_q) << W);
      v3_d    = v2_q;
    end
    if (v3_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Operand and sub-product registers carry no reset; their valids gate them.
  always_ff @(posedge clk) begin
    a1_q    <= a1_d;
    b1_q    <= b1_d;
    mode1_q <= mode1_d;
    ll2_q   <= ll2_d;
    lh2_q   <= lh2_d;
    hl2_q   <= hl2_d;
    hh2_q   <= hh2_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      prod_q <= prod_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
